// File: rtl/d_ff.sv
// d_ff: parameterised D flip-flop with a synchronous, active-high reset.
// q reloads on every rising clk edge, from d or from RESET_VALUE when
// reset is high. There is no enable and no asynchronous set/clear path.
//
// Parameters:
//   WIDTH        data width of d and q, 1 to 64 bits
//   RESET_VALUE  value loaded into q on a reset edge
// Ports:
//   clk    rising-edge clock, the only clock domain
//   reset  synchronous active-high reset, priority over d
//   d      data input, sampled on the rising edge
//   q      registered output, driven straight from the flops

module d_ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Single register; reset is tested first so it wins over d at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed bench for d_ff. Two instances run side by side: the
// default 1-bit one and an 8-bit one with reset value 8'hA5. Inputs change
// on the falling edge; expected q values are queued when driven and popped
// and compared at the next falling edge, after the rising edge loaded them.

module tb_d_ff;

  localparam int unsigned     W8  = 8;
  localparam logic [W8-1:0]   RV8 = 8'hA5;
  localparam logic            RV1 = 1'b0;

  logic          clk;
  logic          reset;
  logic          d1;
  logic          q1;
  logic [W8-1:0] d8;
  logic [W8-1:0] q8;

  int checks;
  int fails;

  logic          exp1_q[$];
  logic [W8-1:0] exp8_q[$];
  string         tag_q[$];

  logic          last1;
  logic [W8-1:0] last8;

  d_ff u_dut1 (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  d_ff #(
    .WIDTH       (W8),
    .RESET_VALUE (RV8)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  // Rising edges at 5, 15, 25 ns ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W8-1:0] obs, input logic [W8-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Queue what both flops must hold after the coming rising edge.
  task automatic push(input logic r, input logic v1, input logic [W8-1:0] v8, input string tag);
    exp1_q.push_back(r ? RV1 : v1);
    exp8_q.push_back(r ? RV8 : v8);
    tag_q.push_back(tag);
  endtask

  // Pop the oldest expectation and compare against both outputs.
  task automatic pop_check();
    logic          e1;
    logic [W8-1:0] e8;
    string         t;
    if (tag_q.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e1 = exp1_q.pop_front();
      e8 = exp8_q.pop_front();
      t  = tag_q.pop_front();
      check({t, "_q1"}, W8'(q1), W8'(e1));
      check({t, "_q8"}, q8, e8);
      last1 = e1;
      last8 = e8;
    end
  endtask

  // One cycle: drive at the falling edge, disturb inputs after the rising
  // edge (must not reach q), compare at the next falling edge.
  task automatic step(input logic r, input logic v1, input logic [W8-1:0] v8, input string tag);
    reset = r;
    d1    = v1;
    d8    = v8;
    push(r, v1, v8, tag);
    @(posedge clk);
    #2;
    reset = 1'($urandom_range(0, 1));
    d1    = ~v1;
    d8    = ~v8;
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    last1  = 1'b0;
    last8  = '0;
    reset  = 1'b1;
    d1     = 1'b0;
    d8     = '0;

    // Reset at 10 ns with d=0; q=0 after the 15 ns edge.
    @(negedge clk);
    step(1'b1, 1'b0, 8'h5A, "reset_first");

    // Release at 20 ns with d=1; first edge loads d, no recovery cycle.
    step(1'b0, 1'b1, 8'h3C, "release_load");
    step(1'b0, 1'b1, 8'h3C, "hold_d1_a");
    step(1'b0, 1'b1, 8'hC3, "hold_d1_b");

    // Reset pulse between rising edges while q=1: no change.
    d1    = 1'b1;
    d8    = 8'h81;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("pulse_during_q1", W8'(q1), W8'(last1));
    check("pulse_during_q8", q8, last8);
    #1 reset = 1'b0;
    #1;
    check("pulse_after_q1", W8'(q1), W8'(last1));
    check("pulse_after_q8", q8, last8);
    push(1'b0, 1'b1, 8'h81, "after_pulse");
    @(posedge clk);
    @(negedge clk);
    pop_check();

    // Reset and d=1 together: reset wins.
    step(1'b1, 1'b1, 8'hFF, "reset_priority");

    // Alternating reset with d=0, three times.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00, "alt_reset_on");
      step(1'b0, 1'b0, 8'h00, "alt_reset_off");
    end

    // Walking pattern then random data with occasional reset edges.
    step(1'b0, 1'b1, 8'h01, "walk_0");
    step(1'b0, 1'b0, 8'h80, "walk_1");
    step(1'b0, 1'b1, 8'hFF, "all_ones");
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           W8'($urandom_range(0, 255)), "random");
    end
    step(1'b1, 1'b1, 8'h00, "final_reset");
    step(1'b0, 1'b1, 8'h00, "final_zero");

    check("queue_drained", W8'(tag_q.size()), W8'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/d_ff.md
D_FF -- requirements
Module: d_ff

Interface
REQ-001 WIDTH, default 1, the data width of d and q in bits; legal range is 1 to 64.
REQ-002 RESET_VALUE, default 0 (WIDTH bits), the value loaded into q by reset.
REQ-003 clk  input  1  single clock for the block; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 d  input  WIDTH  data input, sampled on the rising edge of clk.
REQ-006 q  output  WIDTH  registered data output, driven directly by a flip-flop with no combinational path from any input.

Function
REQ-007 The block SHALL contain exactly one clock domain (clk) and no latches.
REQ-008 On each rising clk edge with reset=0, q SHALL take the value of d sampled at that edge.
REQ-009 On each rising clk edge with reset=1, q SHALL take RESET_VALUE regardless of d.
REQ-010 Reset SHALL have priority over d when both are active at the same edge.
REQ-011 Latency SHALL be exactly one clock cycle from d to q; there is no enable, so q reloads on every edge.
REQ-012 Changes on d or reset between rising edges SHALL NOT affect q until the next rising edge.
REQ-013 q SHALL hold its value between rising edges and SHALL remain glitch-free.
REQ-014 The first rising edge after reset deasserts SHALL load d, with no additional recovery cycle.
REQ-015 Repeated reset pulses of any length of at least one edge SHALL each force q=RESET_VALUE, and the same behavior SHALL apply mid-operation.
REQ-016 Each bit of q SHALL behave independently per REQ-008 to REQ-010 for every WIDTH value.

Reset
REQ-017 Reset SHALL be purely synchronous; asserting reset without a rising clk edge SHALL NOT change q.
REQ-018 After the first rising edge with reset=1, q SHALL equal RESET_VALUE (default 0).
REQ-019 Before the first reset edge or data edge, q has no defined power-on value; a testbench SHALL apply reset before it checks q.
REQ-020 No asynchronous set or clear path SHALL exist.

Verification
REQ-021 Clock period 10 ns, rising edges at 5, 15, 25 ns, and so on: d=0, reset=1 at 10 ns -> q=0 after the 15 ns edge.
REQ-022 Release reset at 20 ns with d=1 -> q=1 after the 25 ns edge, and q stays 1 while d stays 1.
REQ-023 Pulse reset at a falling edge with no rising edge inside the pulse, while q=1 -> q remains 1.
REQ-024 With q=1, assert reset and d=1 together before an edge -> q=0 after that edge (reset has priority).
REQ-025 Alternate reset 1/0 every 10 ns three times with d=0 -> q=0 after every edge, with no X after the first reset edge.
REQ-026 With WIDTH=8 and RESET_VALUE=8'hA5, drive a random d sequence -> q equals d delayed by one edge, and q=8'hA5 after each reset edge.
